ifetch_unit: RTL

Instruction fetch front end for the pipelined MIPS core: owns the PC register and issues one instruction-memory read at a time. It delivers the fetched word plus PC+4 to the IF/ID stage and feeds the current PC and a stall back to the next-PC generator. On redirect (taken branch, jump, jr) it loads the new target from the next-PC generator and discards any in-flight fetch. One request is outstanding at most.

---
 rtl/ifetch_unit.sv | 88 ++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC and keeps at most one instruction-memory read in flight.
// It presents the fetched word and PC+4 to IF/ID and stalls the next-PC generator until it may advance.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nPC,
    input  logic        redirect,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic        fetch_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
);

    localparam logic [1:0] ISSUE   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] VALID   = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    logic [1:0] state;

    assign imem_req    = (state == ISSUE) && !rst;
    assign imem_addr   = PC;
    assign if_pc4      = PC + 32'd4;
    assign fetch_stall = !(((state == VALID) && !id_stall) || redirect);

    // A redirect always retargets the PC; if a read was already accepted its
    // response is still owed by memory, so it must be drained in DISCARD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ISSUE;
            PC       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0000;
        end else begin
            case (state)
                ISSUE: begin
                    if (redirect) begin
                        PC <= nPC;
                    end
                    if (imem_ready) begin
                        state <= redirect ? DISCARD : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect) begin
                            PC    <= nPC;
                            state <= ISSUE;
                        end else begin
                            if_instr <= imem_rdata;
                            if_valid <= 1'b1;
                            state    <= VALID;
                        end
                    end else if (redirect) begin
                        PC    <= nPC;
                        state <= DISCARD;
                    end
                end
                VALID: begin
                    if (!id_stall || redirect) begin
                        PC       <= nPC;
                        if_valid <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        PC <= nPC;
                    end
                    if (imem_rvalid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule
